// File: rtl/fifo_pkg.sv
// Shared types and helpers for the paced circular-queue controller.
package fifo_pkg;

  // Queue depth for a given address width.
  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Occupancy register width for a given address width (holds 0..depth).
  function automatic int unsigned cnt_width(input int unsigned aw);
    return aw + 32'd1;
  endfunction

  // Decode of {rd_ack, wr_ack}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } op_e;

endpackage

// File: rtl/fifo_ctrl_paced_rd_pacer.sv
// Free-running read pacer: rd_ok pulses high once every RD_PERIOD cycles.
module rd_pacer #(
  parameter int unsigned RD_PERIOD = 2
) (
  input  logic clk,
  input  logic reset,
  output logic rd_ok
);

  localparam int unsigned PW = (RD_PERIOD > 1) ? $clog2(RD_PERIOD) : 1;
  localparam logic [PW-1:0] LAST = PW'(RD_PERIOD - 1);

  logic [PW-1:0] cnt;
  logic [PW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt - PW'(1);
    if (cnt == '0) cnt_nxt = LAST;
  end

  // rd_ok registered from the next count so it stays aligned with cnt==0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= LAST;
      rd_ok <= (LAST == '0);
    end else begin
      cnt   <= cnt_nxt;
      rd_ok <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/fifo_ctrl_paced.sv
// Circular-queue controller: pointers, occupancy, level flags, sticky errors,
// with reads gated by a free-running pacer.
module fifo_ctrl_paced
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = depth(ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 2,
  parameter int unsigned RD_PERIOD  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  wr_ack,
  output logic                  rd_ack,
  output logic                  rd_ok,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned D  = depth(ADDR_WIDTH);
  localparam int unsigned CW = cnt_width(ADDR_WIDTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(D);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
  localparam logic          AF_RST   = (AF_LEVEL == 0);

  op_e                  op;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_nxt;
  logic [CW-1:0]         count_nxt;
  logic                  overflow_nxt;
  logic                  underflow_nxt;

  rd_pacer #(.RD_PERIOD(RD_PERIOD)) u_pacer (
    .clk   (clk),
    .reset (reset),
    .rd_ok (rd_ok)
  );

  // A write into a full queue is only accepted alongside an accepted read.
  assign rd_ack = rd & rd_ok & ~empty;
  assign wr_ack = wr & (~full | rd_ack);
  assign op     = op_e'({rd_ack, wr_ack});

  always_comb begin
    w_addr_nxt    = w_addr;
    r_addr_nxt    = r_addr;
    count_nxt     = count;
    case (op)
      OP_WR: begin
        w_addr_nxt = w_addr + ADDR_WIDTH'(1);
        count_nxt  = count + CW'(1);
      end
      OP_RD: begin
        r_addr_nxt = r_addr + ADDR_WIDTH'(1);
        count_nxt  = count - CW'(1);
      end
      OP_RW: begin
        w_addr_nxt = w_addr + ADDR_WIDTH'(1);
        r_addr_nxt = r_addr + ADDR_WIDTH'(1);
      end
      OP_IDLE: ;
    endcase
    // A fresh error in the same cycle as err_clr keeps the flag set.
    overflow_nxt  = (wr & ~wr_ack) | (overflow & ~err_clr);
    underflow_nxt = (rd & rd_ok & empty) | (underflow & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_addr       <= '0;
      r_addr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= AF_RST;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      w_addr       <= w_addr_nxt;
      r_addr       <= r_addr_nxt;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == FULL_CNT);
      almost_empty <= (count_nxt <= AE_CNT);
      almost_full  <= (count_nxt >= AF_CNT);
      overflow     <= overflow_nxt;
      underflow    <= underflow_nxt;
    end
  end

endmodule
